// File: rtl/rr_fifo_arbiter_pkg.sv
// Shared definitions for the arbitrated FIFO: default sizing, entry packing ({tag, data}, tag in MSBs)
// and the producer-lane slicing of the packed wdata bus.
package rr_fifo_arbiter_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_LOG_REQ   = 2;
    localparam int DEF_LOG_DEPTH = 2;
    localparam int DEF_BYTE_SIZE = 8;

    // Producer i owns wdata[lane_lsb(i) +: byte_size].
    function automatic int lane_lsb(input int idx, input int byte_size);
        return idx * byte_size;
    endfunction

    // Stored entry width; tag occupies the top log_req bits.
    function automatic int entry_width(input int log_req, input int byte_size);
        return log_req + byte_size;
    endfunction

endpackage

// File: rtl/rr_fifo_arbiter_if.sv
// Producer/consumer bundle for rr_fifo_arbiter; master = producers + sink, slave = the FIFO.
// Grant is combinational back to the producers; rdata/rtag are first-word fall-through.
interface rr_fifo_arbiter_if
    import rr_fifo_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int LOG_REQ   = DEF_LOG_REQ,
    parameter int BYTE_SIZE = DEF_BYTE_SIZE
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*BYTE_SIZE-1:0] wdata;
    logic [NUM_REQ-1:0]           grant;
    logic                         rreq;
    logic [BYTE_SIZE-1:0]         rdata;
    logic [LOG_REQ-1:0]           rtag;
    logic                         empty;
    logic                         full;

    modport master (
        output req, wdata, rreq,
        input  grant, rdata, rtag, empty, full
    );

    modport slave (
        input  req, wdata, rreq,
        output grant, rdata, rtag, empty, full
    );
endinterface

// File: rtl/rr_fifo_arbiter_arb.sv
// Combinational round-robin pick: first set req bit at or above rr_ptr, wrapping modulo NUM_REQ.
// Zero latency; enable low forces grant to zero.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LOG_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [LOG_REQ-1:0] rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [LOG_REQ-1:0] grant_idx
);

    logic               found;
    logic [LOG_REQ-1:0] idx;

    // NUM_REQ is a power of two, so truncating rr_ptr+k to LOG_REQ bits is the modulo wrap.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + k[LOG_REQ-1:0];
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// Round-robin shared write port onto one FWFT FIFO; grant is same-cycle, head visible one cycle after push.
// Backpressure: no grant while full unless the consumer pops in that same cycle.
module rr_fifo_arbiter
    import rr_fifo_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int LOG_REQ   = DEF_LOG_REQ,
    parameter int LOG_DEPTH = DEF_LOG_DEPTH,
    parameter int BYTE_SIZE = DEF_BYTE_SIZE
) (
    input  logic              clock,
    input  logic              reset,
    rr_fifo_arbiter_if.slave  bus
);

    localparam int DEPTH = 2 ** LOG_DEPTH;

    typedef struct packed {
        logic [LOG_REQ-1:0]   tag;
        logic [BYTE_SIZE-1:0] data;
    } entry_t;

    entry_t               mem_q [DEPTH];
    entry_t               wr_entry;

    logic [LOG_DEPTH-1:0] head_q, head_d;
    logic [LOG_DEPTH-1:0] tail_q, tail_d;
    logic [LOG_DEPTH:0]   count_q, count_d;
    logic [LOG_REQ-1:0]   rr_ptr_q, rr_ptr_d;

    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 accept;
    logic                 arb_en;
    logic [NUM_REQ-1:0]   gnt;
    logic [LOG_REQ-1:0]   gnt_idx;

    assign empty  = (count_q == '0);
    assign full   = (count_q == (LOG_DEPTH+1)'(DEPTH));
    assign pop    = bus.rreq && !empty && !reset;
    // A pop while full frees the slot this same edge, so the arbiter may still grant.
    assign accept = !full || pop;
    assign arb_en = accept && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LOG_REQ (LOG_REQ)
    ) u_arb (
        .req       (bus.req),
        .rr_ptr    (rr_ptr_q),
        .enable    (arb_en),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    assign push = |gnt;

    always_comb begin
        wr_entry      = '0;
        wr_entry.tag  = gnt_idx;
        wr_entry.data = bus.wdata[lane_lsb(int'(gnt_idx), BYTE_SIZE) +: BYTE_SIZE];
    end

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        if (pop) begin
            head_d = head_q + LOG_DEPTH'(1);
        end
        if (push) begin
            tail_d   = tail_q + LOG_DEPTH'(1);
            rr_ptr_d = gnt_idx + LOG_REQ'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (LOG_DEPTH+1)'(1);
            2'b01:   count_d = count_q - (LOG_DEPTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Storage is not reset; push is already held low during reset through arb_en.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[tail_q] <= wr_entry;
        end
    end

    assign bus.grant = gnt;
    assign bus.rdata = mem_q[head_q].data;
    assign bus.rtag  = mem_q[head_q].tag;
    assign bus.empty = empty;
    assign bus.full  = full;

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Directed bench for rr_fifo_arbiter (NUM_REQ=4, LOG_DEPTH=2, BYTE_SIZE=8) with hand-computed expectations.
module tb_rr_fifo_arbiter;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    rr_fifo_arbiter_if #(.NUM_REQ(4), .LOG_REQ(2), .BYTE_SIZE(8)) bus ();

    rr_fifo_arbiter #(
        .NUM_REQ   (4),
        .LOG_REQ   (2),
        .LOG_DEPTH (2),
        .BYTE_SIZE (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 2 time units after it.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk_head(input string tag, input logic [7:0] data, input logic [1:0] tag_v);
        chk_eq({tag, "_rdata"}, 32'(bus.rdata), 32'(data));
        chk_eq({tag, "_rtag"},  32'(bus.rtag),  32'(tag_v));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.req   = 4'b1111;
        bus.wdata = 32'h44332211;
        bus.rreq  = 1'b0;
        tick();
        tick();

        // Reset and idle
        chk_eq("rst_grant", 32'(bus.grant), 32'h0);
        chk_eq("rst_empty", 32'(bus.empty), 32'h1);
        chk_eq("rst_full",  32'(bus.full),  32'h0);
        reset    = 1'b0;
        bus.req  = 4'b0000;
        bus.rreq = 1'b1;
        #1;
        chk_eq("idle_grant", 32'(bus.grant), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("idle_empty", 32'(bus.empty), 32'h1);
            chk_eq("idle_count", 32'(dut.count_q), 32'h0);
        end

        // Full round-robin fill
        bus.rreq  = 1'b0;
        bus.req   = 4'b1111;
        bus.wdata = 32'h44332211;
        #1;
        chk_eq("fill_g0", 32'(bus.grant), 32'h1);
        tick();
        chk_eq("fill_g1", 32'(bus.grant), 32'h2);
        chk_head("fill_head", 8'h11, 2'd0);
        tick();
        chk_eq("fill_g2", 32'(bus.grant), 32'h4);
        tick();
        chk_eq("fill_g3", 32'(bus.grant), 32'h8);
        tick();
        chk_eq("fill_full",  32'(bus.full),  32'h1);
        chk_eq("fill_gfull", 32'(bus.grant), 32'h0);
        bus.req  = 4'b0000;
        bus.rreq = 1'b1;
        #1;
        chk_head("pop0", 8'h11, 2'd0);
        tick();
        chk_head("pop1", 8'h22, 2'd1);
        tick();
        chk_head("pop2", 8'h33, 2'd2);
        tick();
        chk_head("pop3", 8'h44, 2'd3);
        tick();
        chk_eq("pop_empty", 32'(bus.empty), 32'h1);
        chk_eq("pop_rrptr", 32'(dut.rr_ptr_q), 32'h0);

        // Skip idle requesters
        bus.rreq  = 1'b0;
        bus.req   = 4'b0100;
        bus.wdata = 32'h005A0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_eq("skip_grant", 32'(bus.grant), 32'h4);
            tick();
        end
        chk_eq("skip_count", 32'(dut.count_q), 32'h3);
        chk_eq("skip_rrptr", 32'(dut.rr_ptr_q), 32'h3);
        chk_head("skip_head", 8'h5A, 2'd2);

        // Top up to full from rr_ptr=3: producer 0 wins after wrapping
        bus.req   = 4'b0001;
        bus.wdata = 32'h00000077;
        #1;
        chk_eq("wrap_grant", 32'(bus.grant), 32'h1);
        tick();
        chk_eq("wrap_full", 32'(bus.full), 32'h1);

        // Backpressure: no pop, no grant
        bus.req   = 4'b0010;
        bus.wdata = 32'h00002200;
        #1;
        chk_eq("bp_grant", 32'(bus.grant), 32'h0);
        // Pop-through while full
        bus.rreq = 1'b1;
        #1;
        chk_eq("pt_grant", 32'(bus.grant), 32'h2);
        tick();
        chk_eq("pt_count", 32'(dut.count_q), 32'h4);
        chk_eq("pt_full",  32'(bus.full),    32'h1);
        bus.req = 4'b0000;
        #1;
        chk_head("pt_h0", 8'h5A, 2'd2);
        tick();
        chk_head("pt_h1", 8'h5A, 2'd2);
        tick();
        chk_head("pt_h2", 8'h77, 2'd0);
        tick();
        chk_head("pt_h3", 8'h22, 2'd1);
        tick();
        chk_eq("pt_empty", 32'(bus.empty), 32'h1);
        chk_eq("pt_rrptr", 32'(dut.rr_ptr_q), 32'h2);

        // Mid-operation reset
        bus.rreq  = 1'b0;
        bus.req   = 4'b1111;
        bus.wdata = 32'h44332211;
        #1;
        chk_eq("mr_g0", 32'(bus.grant), 32'h4);
        tick();
        chk_eq("mr_g1", 32'(bus.grant), 32'h8);
        tick();
        chk_eq("mr_g2", 32'(bus.grant), 32'h1);
        tick();
        chk_eq("mr_count", 32'(dut.count_q), 32'h3);
        reset = 1'b1;
        #1;
        chk_eq("mr_rst_grant", 32'(bus.grant), 32'h0);
        tick();
        reset   = 1'b0;
        bus.req = 4'b0000;
        #1;
        chk_eq("mr_empty", 32'(bus.empty), 32'h1);
        chk_eq("mr_grant", 32'(bus.grant), 32'h0);
        chk_eq("mr_rrptr", 32'(dut.rr_ptr_q), 32'h0);
        bus.req = 4'b1111;
        #1;
        chk_eq("mr_first_grant", 32'(bus.grant), 32'h1);
        tick();
        chk_eq("mr_post_empty", 32'(bus.empty), 32'h0);
        chk_head("mr_post_head", 8'h11, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
